// File: rtl/oka_operand_split_32bit.sv
// Front end of the overlap-free Karatsuba (OKA) GF(2)[x] multiplier.
// Splits two N-bit operands into even/odd coefficient halves, issues the
// four half-width sub-products to a shared external carry-less multiplier
// one at a time, and presents the collected results as term1..term4.
module oka_operand_split_32bit #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           sub_valid,
  input  logic           sub_ready,
  output logic [1:0]     sub_idx,
  output logic [N/2-1:0] sub_a,
  output logic [N/2-1:0] sub_b,
  input  logic           res_valid,
  input  logic [N-2:0]   res_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-2:0]   term1,
  output logic [N-2:0]   term2,
  output logic [N-2:0]   term3,
  output logic [N-2:0]   term4,
  output logic           err_sticky
);

  localparam int H = N / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [1:0]   k;
  logic [1:0]   k_nxt;
  logic [H-1:0] ae, ao, be, bo;

  // Coefficients of x^(2i) of an operand.
  function automatic logic [H-1:0] even_bits(input logic [N-1:0] v);
    logic [H-1:0] r;
    for (int i = 0; i < H; i++) r[i] = v[2*i];
    return r;
  endfunction

  // Coefficients of x^(2i+1) of an operand.
  function automatic logic [H-1:0] odd_bits(input logic [N-1:0] v);
    logic [H-1:0] r;
    for (int i = 0; i < H; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  // Handshake flags are pure state decodes, so no input reaches them
  // combinationally.
  assign in_ready  = (state == IDLE);
  assign sub_valid = (state == ISSUE);
  assign out_valid = (state == DONE);
  assign sub_idx   = k;
  assign k_nxt     = k + 2'd1;

  // Sequencer: capture halves, walk the four requests, collect results.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= 2'd0;
      ae         <= '0;
      ao         <= '0;
      be         <= '0;
      bo         <= '0;
      sub_a      <= '0;
      sub_b      <= '0;
      term1      <= '0;
      term2      <= '0;
      term3      <= '0;
      term4      <= '0;
      err_sticky <= 1'b0;
    end else begin
      // A result strobe is only meaningful while a request is outstanding.
      if (res_valid && state != WAIT) err_sticky <= 1'b1;

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ae    <= even_bits(a_in);
            ao    <= odd_bits(a_in);
            be    <= even_bits(b_in);
            bo    <= odd_bits(b_in);
            // Request 0 is (Ae, Be), taken straight from the inputs.
            sub_a <= even_bits(a_in);
            sub_b <= even_bits(b_in);
            k     <= 2'd0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (sub_ready) state <= WAIT;
        end
        WAIT: begin
          if (res_valid) begin
            unique case (k)
              2'd0: term1 <= res_data;
              2'd1: term2 <= res_data;
              2'd2: term3 <= res_data;
              2'd3: term4 <= res_data;
            endcase
            if (k == 2'd3) begin
              state <= DONE;
            end else begin
              // k bit 1 selects the A half, bit 0 selects the B half.
              k     <= k_nxt;
              sub_a <= k_nxt[1] ? ao : ae;
              sub_b <= k_nxt[0] ? bo : be;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oka_operand_split_32bit.sv
// Self-checking bench for oka_operand_split_32bit. The bench plays the
// external carry-less multiplier and keeps an arithmetic model of the
// expected request stream, terms and error flag.
module tb_oka_operand_split_32bit;

  localparam int N = 32;
  localparam int H = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_in, b_in;
  logic          sub_valid;
  logic          sub_ready;
  logic [1:0]    sub_idx;
  logic [H-1:0]  sub_a, sub_b;
  logic          res_valid;
  logic [N-2:0]  res_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-2:0]  term1, term2, term3, term4;
  logic          err_sticky;

  // Multiplier responder outputs and bench-injected stray results.
  logic          auto_rv = 1'b0;
  logic [N-2:0]  auto_rd = '0;
  logic          auto_sr = 1'b1;
  logic          inj_rv;
  logic [N-2:0]  inj_rd;

  assign res_valid = auto_rv | inj_rv;
  assign res_data  = inj_rv ? inj_rd : auto_rd;
  assign sub_ready = auto_sr;

  always #5 clk = ~clk;

  oka_operand_split_32bit #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_idx(sub_idx),
    .sub_a(sub_a), .sub_b(sub_b),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .term1(term1), .term2(term2), .term3(term3), .term4(term4),
    .err_sticky(err_sticky)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain shift-and-xor polynomial product.
  function automatic logic [63:0] clmul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (y[i]) r = r ^ (64'(x) << i);
    return r;
  endfunction

  function automatic void split(input logic [31:0] v, output logic [15:0] e, output logic [15:0] o);
    for (int i = 0; i < 16; i++) begin
      e[i] = v[2*i];
      o[i] = v[2*i+1];
    end
  endfunction

  // Rebuild the full product from the four terms.
  function automatic logic [63:0] recombine(input logic [30:0] t1, input logic [30:0] t2,
                                            input logic [30:0] t3, input logic [30:0] t4);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < 31) p[2*i] = t1[i];
      if (i > 0) p[2*i] = p[2*i] ^ t4[i-1];
      if (i < 31) p[2*i+1] = t2[i] ^ t3[i];
    end
    return p;
  endfunction

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  function automatic req_t mk_req(input logic [1:0] idx, input logic [15:0] a, input logic [15:0] b);
    req_t r;
    r.idx = idx;
    r.a   = a;
    r.b   = b;
    return r;
  endfunction

  // ---------------- model and compare process ----------------
  req_t         exp_q[$];
  req_t         log_q[$];
  logic [30:0]  exp_t [4];
  bit           mdl_wait = 1'b0;
  bit           mdl_err  = 1'b0;
  int           out_cnt  = 0;
  bit           hs_pend  = 1'b0;
  req_t         hs_r;
  logic [15:0]  m_ae, m_ao, m_be, m_bo;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_wait = 1'b0;
      mdl_err  = 1'b0;
      hs_pend  = 1'b0;
    end else begin
      check("err_sticky", 64'(err_sticky), 64'(mdl_err));
      if (res_valid) begin
        if (mdl_wait) mdl_wait = 1'b0;
        else          mdl_err  = 1'b1;
      end
      if (in_valid && in_ready) begin
        split(a_in, m_ae, m_ao);
        split(b_in, m_be, m_bo);
        exp_q.delete();
        exp_q.push_back(mk_req(2'd0, m_ae, m_be));
        exp_q.push_back(mk_req(2'd1, m_ae, m_bo));
        exp_q.push_back(mk_req(2'd2, m_ao, m_be));
        exp_q.push_back(mk_req(2'd3, m_ao, m_bo));
        exp_t[0] = 31'(clmul(32'(m_ae), 32'(m_be)));
        exp_t[1] = 31'(clmul(32'(m_ae), 32'(m_bo)));
        exp_t[2] = 31'(clmul(32'(m_ao), 32'(m_be)));
        exp_t[3] = 31'(clmul(32'(m_ao), 32'(m_bo)));
      end
      hs_pend = 1'b0;
      if (sub_valid) begin
        if (exp_q.size() == 0) begin
          check("sub_valid_without_request", 64'(sub_valid), 64'(0));
        end else begin
          check("sub_idx", 64'(sub_idx), 64'(exp_q[0].idx));
          check("sub_a",   64'(sub_a),   64'(exp_q[0].a));
          check("sub_b",   64'(sub_b),   64'(exp_q[0].b));
          if (sub_ready) begin
            hs_pend = 1'b1;
            hs_r    = mk_req(sub_idx, sub_a, sub_b);
            log_q.push_back(hs_r);
            void'(exp_q.pop_front());
            mdl_wait = 1'b1;
          end
        end
      end
      if (out_valid) begin
        out_cnt++;
        check("term1", 64'(term1), 64'(exp_t[0]));
        check("term2", 64'(term2), 64'(exp_t[1]));
        check("term3", 64'(term3), 64'(exp_t[2]));
        check("term4", 64'(term4), 64'(exp_t[3]));
      end
    end
  end

  // ---------------- multiplier responder ----------------
  int stall_idx = -1;
  int stall_len = 0;
  int stall_gen = 0;
  int drop_idx  = -1;
  int my_gen    = 0;
  int left      = 0;

  always @(posedge clk) begin
    #1;
    if (my_gen != stall_gen) begin
      my_gen = stall_gen;
      left   = stall_len;
    end
    auto_rv = hs_pend && rst_n && (int'(hs_r.idx) != drop_idx);
    auto_rd = 31'(clmul(32'(hs_r.a), 32'(hs_r.b)));
    auto_sr = 1'b1;
    if (sub_valid && int'(sub_idx) == stall_idx && left > 0) begin
      auto_sr = 1'b0;
      left--;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    check("in_ready_before_op", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check("out_valid_reached", 64'(out_valid), 64'(1));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),   64'(1));
    check({tag, "_sub_valid"}, 64'(sub_valid),  64'(0));
    check({tag, "_sub_idx"},   64'(sub_idx),    64'(0));
    check({tag, "_sub_a"},     64'(sub_a),      64'(0));
    check({tag, "_sub_b"},     64'(sub_b),      64'(0));
    check({tag, "_out_valid"}, 64'(out_valid),  64'(0));
    check({tag, "_term1"},     64'(term1),      64'(0));
    check({tag, "_term2"},     64'(term2),      64'(0));
    check({tag, "_term3"},     64'(term3),      64'(0));
    check({tag, "_term4"},     64'(term4),      64'(0));
    check({tag, "_err"},       64'(err_sticky), 64'(0));
  endtask

  task automatic check_req(input int base, input int i, input logic [15:0] ea, input logic [15:0] eb);
    if (log_q.size() > base + i) begin
      check("req_idx", 64'(log_q[base+i].idx), 64'(i));
      check("req_a",   64'(log_q[base+i].a),   64'(ea));
      check("req_b",   64'(log_q[base+i].b),   64'(eb));
    end else begin
      check("req_count", 64'(log_q.size()), 64'(base + i + 1));
    end
  endtask

  task automatic check_product(input string tag, input logic [31:0] a, input logic [31:0] b);
    check(tag, recombine(term1, term2, term3, term4), clmul(a, b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int g;
    int out_before;
    logic [15:0] e_a, o_a, e_b, o_b;
    logic [30:0] t3_exp [4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; inj_rv = 1'b0; inj_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset("init");

    // Minimum-latency run with true products.
    base = log_q.size();
    start_op(32'h0000_0003, 32'h0000_0001);
    wait_done(cyc);
    check("t1_latency", 64'(cyc), 64'(9));
    tick();
    check("t1_term1", 64'(term1), 64'(1));
    check("t1_term2", 64'(term2), 64'(0));
    check("t1_term3", 64'(term3), 64'(1));
    check("t1_term4", 64'(term4), 64'(0));
    check("t1_in_ready_after", 64'(in_ready), 64'(1));
    check_req(base, 0, 16'h0001, 16'h0001);
    check_req(base, 1, 16'h0001, 16'h0000);
    check_req(base, 2, 16'h0001, 16'h0001);
    check_req(base, 3, 16'h0001, 16'h0000);

    // Split check.
    base = log_q.size();
    start_op(32'hFFFF_FFFF, 32'hAAAA_AAAA);
    wait_done(cyc);
    tick();
    check("t2_term1", 64'(term1), 64'(0));
    check("t2_term2", 64'(term2), 64'h5555_5555);
    check("t2_term3", 64'(term3), 64'(0));
    check("t2_term4", 64'(term4), 64'h5555_5555);
    check_req(base, 0, 16'hFFFF, 16'h0000);
    check_req(base, 1, 16'hFFFF, 16'hFFFF);
    check_req(base, 2, 16'hFFFF, 16'h0000);
    check_req(base, 3, 16'hFFFF, 16'hFFFF);

    // Backpressure on both sides.
    stall_idx = 2; stall_len = 5; stall_gen++;
    out_ready = 1'b0;
    start_op(32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(cyc);
    check("t3_latency_with_stall", 64'(cyc), 64'(14));
    for (int i = 0; i < 4; i++) begin
      check("t3_in_ready_held_low", 64'(in_ready), 64'(0));
      check("t3_out_valid_held", 64'(out_valid), 64'(1));
      tick();
    end
    check_product("t3_product", 32'h1234_5678, 32'h9ABC_DEF0);
    out_ready = 1'b1;
    tick();
    check("t3_out_valid_dropped", 64'(out_valid), 64'(0));
    check("t3_in_ready_back", 64'(in_ready), 64'(1));
    stall_idx = -1;
    split(32'h1234_5678, e_a, o_a);
    split(32'h9ABC_DEF0, e_b, o_b);
    t3_exp[0] = 31'(clmul(32'(e_a), 32'(e_b)));
    t3_exp[1] = 31'(clmul(32'(e_a), 32'(o_b)));
    t3_exp[2] = 31'(clmul(32'(o_a), 32'(e_b)));
    t3_exp[3] = 31'(clmul(32'(o_a), 32'(o_b)));

    // Stray result in IDLE.
    inj_rd = 31'h7FFF_FFFF;
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    check("t4_err_after_idle_stray", 64'(err_sticky), 64'(1));
    check("t4_term1_kept", 64'(term1), 64'(t3_exp[0]));
    check("t4_term2_kept", 64'(term2), 64'(t3_exp[1]));
    check("t4_term3_kept", 64'(term3), 64'(t3_exp[2]));
    check("t4_term4_kept", 64'(term4), 64'(t3_exp[3]));

    // Stray result in ISSUE; the operation must still complete correctly.
    stall_idx = 0; stall_len = 3; stall_gen++;
    start_op(32'h8000_0001, 32'hF00D_C0DE);
    inj_rd = 31'h2AAA_AAAA;
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    wait_done(cyc);
    tick();
    check("t4_err_still_set", 64'(err_sticky), 64'(1));
    check_product("t4_product", 32'h8000_0001, 32'hF00D_C0DE);
    stall_idx = -1;

    // Reset while waiting for the result of request 1.
    drop_idx = 1;
    base = log_q.size();
    start_op(32'hDEAD_BEEF, 32'h0F0F_1234);
    g = 0;
    while (log_q.size() < base + 2 && g < 50) begin
      tick();
      g++;
    end
    check("t5_reached_wait_idx1", 64'(log_q.size()), 64'(base + 2));
    tick();
    out_before = out_cnt;
    rst_n = 1'b0;
    #1;
    check_reset("t5_mid");
    tick();
    rst_n = 1'b1;
    drop_idx = -1;
    tick();
    check("t5_idle_after_reset", 64'(in_ready), 64'(1));
    check("t5_no_out_valid_now", 64'(out_valid), 64'(0));
    inj_rd = 31'h0000_1111;
    inj_rv = 1'b1;
    tick();
    inj_rv = 1'b0;
    check("t5_late_res_sets_err", 64'(err_sticky), 64'(1));
    check("t5_out_valid_never", 64'(out_cnt), 64'(out_before));

    // Fresh operation after the abandoned one.
    start_op(32'hCAFE_F00D, 32'h1357_9BDF);
    wait_done(cyc);
    check("t5_fresh_latency", 64'(cyc), 64'(9));
    tick();
    check_product("t5_product", 32'hCAFE_F00D, 32'h1357_9BDF);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
